// File: rtl/esc_instruction_fetch_decoder_pkg.sv
// Shared definitions for the x87 ESC instruction fetch/decode front end:
// opcode prefix, parser states and ModR/M field encodings.
package esc_instruction_fetch_decoder_pkg;

  localparam int DEFAULT_COUNT_W = 16;

  // Every x87 escape opcode (D8..DF) carries this value in bits [7:3].
  localparam logic [4:0] ESC_PREFIX = 5'b11011;

  typedef enum logic [2:0] {
    S_OPCODE  = 3'd0,
    S_MODRM   = 3'd1,
    S_DISP_LO = 3'd2,
    S_DISP_HI = 3'd3,
    S_PRESENT = 3'd4
  } state_e;

  // ModR/M mod field encodings (16-bit addressing form).
  localparam logic [1:0] MOD_NODISP = 2'b00;
  localparam logic [1:0] MOD_DISP8  = 2'b01;
  localparam logic [1:0] MOD_DISP16 = 2'b10;
  localparam logic [1:0] MOD_REG    = 2'b11;

  // With mod=00 this rm value means a bare 16-bit direct address follows.
  localparam logic [2:0] RM_DIRECT = 3'b110;

  function automatic logic is_esc(input logic [7:0] b);
    return b[7:3] == ESC_PREFIX;
  endfunction

endpackage

// File: rtl/esc_instruction_fetch_decoder_if.sv
// Byte-stream input and instruction-port output of the ESC decoder.
// The slave modport is the decoder's view, master is the driver/consumer view.
interface esc_instruction_fetch_decoder_if #(
  parameter int COUNT_W = esc_instruction_fetch_decoder_pkg::DEFAULT_COUNT_W
);
  logic               flush;
  logic [7:0]         byte_in;
  logic               byte_valid;
  logic               byte_ready;
  logic [7:0]         instr_opcode;
  logic [7:0]         instr_modrm;
  logic [15:0]        instr_disp;
  logic               instr_has_mem;
  logic [2:0]         instr_len;
  logic               instr_valid;
  logic               instr_ack;
  logic [COUNT_W-1:0] instr_count;
  logic [COUNT_W-1:0] drop_count;

  modport slave (
    input  flush, byte_in, byte_valid, instr_ack,
    output byte_ready, instr_opcode, instr_modrm, instr_disp, instr_has_mem,
           instr_len, instr_valid, instr_count, drop_count
  );

  modport master (
    output flush, byte_in, byte_valid, instr_ack,
    input  byte_ready, instr_opcode, instr_modrm, instr_disp, instr_has_mem,
           instr_len, instr_valid, instr_count, drop_count
  );
endinterface

// File: rtl/esc_instruction_fetch_decoder_disp_len.sv
// Combinational ModR/M classifier: how many displacement bytes follow the
// ModR/M byte and whether the operand is in memory.
module esc_instruction_fetch_decoder_disp_len
  import esc_instruction_fetch_decoder_pkg::*;
(
  input  logic [1:0] mod_i,
  input  logic [2:0] rm_i,
  output logic [1:0] disp_bytes_o,
  output logic       has_mem_o
);

  // Decode mod/rm into displacement size and memory-operand flag.
  always_comb begin
    disp_bytes_o = 2'd0;
    has_mem_o    = 1'b1;
    case (mod_i)
      MOD_REG:    has_mem_o    = 1'b0;
      MOD_DISP8:  disp_bytes_o = 2'd1;
      MOD_DISP16: disp_bytes_o = 2'd2;
      // MOD_NODISP: only the direct-address form carries a 16-bit field
      default:    disp_bytes_o = (rm_i == RM_DIRECT) ? 2'd2 : 2'd0;
    endcase
  end

endmodule

// File: rtl/esc_instruction_fetch_decoder.sv
// Parses x87 ESC instructions (opcode, ModR/M, optional displacement) out of
// the prefetch byte stream and presents them one at a time on a valid/ack port.
module esc_instruction_fetch_decoder
  import esc_instruction_fetch_decoder_pkg::*;
#(
  parameter bit PASS_NON_ESC = 1'b1,
  parameter int COUNT_W      = DEFAULT_COUNT_W
) (
  input  logic                          clk,
  input  logic                          reset,
  esc_instruction_fetch_decoder_if.slave bus
);

  state_e             state_q, state_d;
  logic [7:0]         opcode_q, opcode_d;
  logic [7:0]         modrm_q, modrm_d;
  logic [15:0]        disp_q, disp_d;
  logic               has_mem_q, has_mem_d;
  logic [2:0]         len_q, len_d;
  logic               valid_q, valid_d;
  logic               disp16_q, disp16_d;
  logic [COUNT_W-1:0] instr_count_q, instr_count_d;
  logic [COUNT_W-1:0] drop_count_q, drop_count_d;

  logic       byte_ready_c;
  logic       accept_c;
  logic [7:0] b;
  logic [1:0] map_disp_bytes;
  logic       map_has_mem;

  // A flush cycle refuses the offered byte so it is neither parsed nor lost.
  assign byte_ready_c = (state_q != S_PRESENT) && !bus.flush;
  assign accept_c     = bus.byte_valid && byte_ready_c;
  assign b            = bus.byte_in;

  // Classify the incoming byte as a ModR/M candidate.
  esc_instruction_fetch_decoder_disp_len u_disp_len (
    .mod_i        (b[7:6]),
    .rm_i         (b[2:0]),
    .disp_bytes_o (map_disp_bytes),
    .has_mem_o    (map_has_mem)
  );

  // Next-state logic: parser FSM, field assembly and statistics counters.
  always_comb begin
    state_d       = state_q;
    opcode_d      = opcode_q;
    modrm_d       = modrm_q;
    disp_d        = disp_q;
    has_mem_d     = has_mem_q;
    len_d         = len_q;
    valid_d       = valid_q;
    disp16_d      = disp16_q;
    instr_count_d = instr_count_q;
    drop_count_d  = drop_count_q;

    if (bus.flush) begin
      state_d   = S_OPCODE;
      valid_d   = 1'b0;
      opcode_d  = 8'h00;
      modrm_d   = 8'h00;
      disp_d    = 16'h0000;
      has_mem_d = 1'b0;
      len_d     = 3'd0;
      disp16_d  = 1'b0;
    end else begin
      case (state_q)
        S_OPCODE: begin
          if (accept_c) begin
            if (is_esc(b)) begin
              opcode_d  = b;
              modrm_d   = 8'h00;
              disp_d    = 16'h0000;
              has_mem_d = 1'b0;
              len_d     = 3'd1;
              state_d   = S_MODRM;
            end else if (PASS_NON_ESC) begin
              opcode_d  = b;
              modrm_d   = 8'h00;
              disp_d    = 16'h0000;
              has_mem_d = 1'b0;
              len_d     = 3'd1;
              valid_d   = 1'b1;
              state_d   = S_PRESENT;
            end else begin
              drop_count_d = drop_count_q + COUNT_W'(1);
            end
          end
        end
        S_MODRM: begin
          if (accept_c) begin
            modrm_d   = b;
            has_mem_d = map_has_mem;
            len_d     = 3'd2;
            if (map_disp_bytes == 2'd0) begin
              valid_d = 1'b1;
              state_d = S_PRESENT;
            end else begin
              disp16_d = (map_disp_bytes == 2'd2);
              state_d  = S_DISP_LO;
            end
          end
        end
        S_DISP_LO: begin
          if (accept_c) begin
            if (disp16_q) begin
              disp_d  = {8'h00, b};
              state_d = S_DISP_HI;
            end else begin
              disp_d  = {{8{b[7]}}, b};
              len_d   = 3'd3;
              valid_d = 1'b1;
              state_d = S_PRESENT;
            end
          end
        end
        S_DISP_HI: begin
          if (accept_c) begin
            disp_d  = {b, disp_q[7:0]};
            len_d   = 3'd4;
            valid_d = 1'b1;
            state_d = S_PRESENT;
          end
        end
        S_PRESENT: begin
          // Returning to S_OPCODE on the ack edge forces a valid-low cycle
          // before the next instruction can be presented.
          if (bus.instr_ack) begin
            valid_d       = 1'b0;
            instr_count_d = instr_count_q + COUNT_W'(1);
            state_d       = S_OPCODE;
          end
        end
        default: state_d = S_OPCODE;
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_OPCODE;
      opcode_q      <= 8'h00;
      modrm_q       <= 8'h00;
      disp_q        <= 16'h0000;
      has_mem_q     <= 1'b0;
      len_q         <= 3'd0;
      valid_q       <= 1'b0;
      disp16_q      <= 1'b0;
      instr_count_q <= '0;
      drop_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      opcode_q      <= opcode_d;
      modrm_q       <= modrm_d;
      disp_q        <= disp_d;
      has_mem_q     <= has_mem_d;
      len_q         <= len_d;
      valid_q       <= valid_d;
      disp16_q      <= disp16_d;
      instr_count_q <= instr_count_d;
      drop_count_q  <= drop_count_d;
    end
  end

  assign bus.byte_ready    = byte_ready_c;
  assign bus.instr_opcode  = opcode_q;
  assign bus.instr_modrm   = modrm_q;
  assign bus.instr_disp    = disp_q;
  assign bus.instr_has_mem = has_mem_q;
  assign bus.instr_len     = len_q;
  assign bus.instr_valid   = valid_q;
  assign bus.instr_count   = instr_count_q;
  assign bus.drop_count    = drop_count_q;

endmodule

// File: tb/tb_esc_instruction_fetch_decoder.sv
// Bench for esc_instruction_fetch_decoder: table vectors, hand-written
// corner sequences and random streams checked against a byte-stream parser.
module tb_esc_instruction_fetch_decoder;

  typedef struct {
    logic [7:0]  op;
    logic [7:0]  modrm;
    logic [15:0] disp;
    logic        has_mem;
    logic [2:0]  len;
    int          end_idx;
  } instr_t;

  typedef struct {
    logic [31:0] bytes;
    int          n;
    logic [7:0]  op;
    logic [7:0]  modrm;
    logic [15:0] disp;
    logic        has_mem;
    logic [2:0]  len;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset, flush, byte_valid, instr_ack, sel;
  logic [7:0] byte_in;
  int         vectors = 0;
  int         miscompares = 0;
  int         exp_icnt = 0;
  int         exp_dcnt = 0;

  always #5 clk = ~clk;

  esc_instruction_fetch_decoder_if #(.COUNT_W(16)) bus0 ();
  esc_instruction_fetch_decoder_if #(.COUNT_W(16)) bus1 ();

  assign bus0.flush = flush;  assign bus0.byte_in = byte_in;
  assign bus0.byte_valid = byte_valid;  assign bus0.instr_ack = instr_ack;
  assign bus1.flush = flush;  assign bus1.byte_in = byte_in;
  assign bus1.byte_valid = byte_valid;  assign bus1.instr_ack = instr_ack;

  esc_instruction_fetch_decoder #(.PASS_NON_ESC(1'b1), .COUNT_W(16)) dut_pass (
    .clk(clk), .reset(reset), .bus(bus0));
  esc_instruction_fetch_decoder #(.PASS_NON_ESC(1'b0), .COUNT_W(16)) dut_drop (
    .clk(clk), .reset(reset), .bus(bus1));

  logic        obs_valid, obs_ready, obs_mem;
  logic [7:0]  obs_op, obs_modrm;
  logic [15:0] obs_disp, obs_icnt, obs_dcnt;
  logic [2:0]  obs_len;
  assign obs_valid = sel ? bus1.instr_valid   : bus0.instr_valid;
  assign obs_ready = sel ? bus1.byte_ready    : bus0.byte_ready;
  assign obs_mem   = sel ? bus1.instr_has_mem : bus0.instr_has_mem;
  assign obs_op    = sel ? bus1.instr_opcode  : bus0.instr_opcode;
  assign obs_modrm = sel ? bus1.instr_modrm   : bus0.instr_modrm;
  assign obs_disp  = sel ? bus1.instr_disp    : bus0.instr_disp;
  assign obs_len   = sel ? bus1.instr_len     : bus0.instr_len;
  assign obs_icnt  = sel ? bus1.instr_count   : bus0.instr_count;
  assign obs_dcnt  = sel ? bus1.drop_count    : bus0.drop_count;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else
      $display("ok   %s: %0h", name, act);
  endtask

  function automatic logic [63:0] obs_fields();
    return 64'({obs_op, obs_modrm, obs_disp, obs_mem, obs_len});
  endfunction

  function automatic logic [63:0] rec_fields(input instr_t r);
    return 64'({r.op, r.modrm, r.disp, r.has_mem, r.len});
  endfunction

  // Number of displacement bytes implied by a ModR/M byte (16-bit addressing).
  function automatic int disp_bytes_of(input logic [7:0] m);
    int md, rm;
    md = int'(m) / 64;
    rm = int'(m) % 8;
    if (md == 1) return 1;
    if (md == 2 || (md == 0 && rm == 6)) return 2;
    return 0;
  endfunction

  // Reference parser: splits a complete byte stream into instructions.
  task automatic model(input logic [7:0] s[$], input bit pass,
                       output instr_t out[$], output int drops);
    int i, nd, d;
    instr_t r;
    out.delete();
    drops = 0;
    i = 0;
    while (i < s.size()) begin
      if (s[i] >= 8'hD8 && s[i] <= 8'hDF) begin
        nd = disp_bytes_of(s[i+1]);
        r.op = s[i];
        r.modrm = s[i+1];
        r.has_mem = (int'(s[i+1]) / 64) != 3;
        r.len = 3'(2 + nd);
        if (nd == 0) d = 0;
        else if (nd == 1) d = (s[i+2] < 128) ? int'(s[i+2]) : int'(s[i+2]) + 65280;
        else d = int'(s[i+2]) + 256 * int'(s[i+3]);
        r.disp = 16'(d);
        r.end_idx = i + 1 + nd;
        out.push_back(r);
        i += 2 + nd;
      end else if (pass) begin
        r.op = s[i]; r.modrm = 8'h00; r.disp = 16'h0000;
        r.has_mem = 1'b0; r.len = 3'd1; r.end_idx = i;
        out.push_back(r);
        i++;
      end else begin
        drops++;
        i++;
      end
    end
  endtask

  // Random stream of complete instructions; non-ESC bytes mixed in if allowed.
  task automatic gen(input int n, input bit allow_non, output logic [7:0] s[$]);
    logic [7:0] b, m;
    s.delete();
    for (int k = 0; k < n; k++) begin
      if (allow_non && $urandom_range(99, 0) < 20) begin
        do b = 8'($urandom); while (b >= 8'hD8 && b <= 8'hDF);
        s.push_back(b);
      end else begin
        s.push_back(8'hD8 + 8'($urandom_range(7, 0)));
        m = 8'($urandom);
        s.push_back(m);
        for (int j = 0; j < disp_bytes_of(m); j++) s.push_back(8'($urandom));
      end
    end
  endtask

  // Feeds a stream with random byte gaps and ack delays; checks every
  // presented instruction (1-cycle latency), the valid gap after each ack
  // and the counters at the end. Entered and left on a falling edge.
  task automatic run_stream(input logic [7:0] s[$], input instr_t exp_in[$],
                            input int gap_pct, input int ack_min, input int ack_max);
    instr_t exp[$];
    instr_t cur;
    int idx, wait_cnt, delay, cyc;
    bit expect_next, presenting, acked_prev, acc;
    exp = exp_in;
    idx = 0; cyc = 0; wait_cnt = 0; delay = 0;
    expect_next = 0; presenting = 0; acked_prev = 0;
    while ((idx < s.size() || exp.size() > 0 || presenting || expect_next || acked_prev)
           && cyc < 20000) begin
      if (acked_prev) begin
        chk("valid_low_after_ack", 64'(obs_valid), 64'(0));
        acked_prev = 0;
      end else if (expect_next) begin
        cur = exp.pop_front();
        expect_next = 0;
        chk("valid_latency", 64'(obs_valid), 64'(1));
        chk("ready_low_while_present", 64'(obs_ready), 64'(0));
        chk("instr_fields", obs_fields(), rec_fields(cur));
        presenting = 1;
        wait_cnt = 0;
        delay = $urandom_range(ack_max, ack_min);
      end else if (!presenting && obs_valid !== 1'b0) begin
        chk("spurious_valid", 64'(obs_valid), 64'(0));
      end
      instr_ack = 1'b0;
      if (presenting) begin
        if (wait_cnt >= delay) begin
          instr_ack = 1'b1;
          presenting = 0;
          acked_prev = 1;
          exp_icnt++;
        end else wait_cnt++;
      end
      byte_valid = (idx < s.size()) && ($urandom_range(99, 0) >= gap_pct);
      byte_in = (idx < s.size()) ? s[idx] : 8'($urandom);
      #1;
      acc = byte_valid && obs_ready;
      @(posedge clk);
      if (acc) begin
        if (exp.size() > 0 && exp[0].end_idx == idx) expect_next = 1;
        idx++;
      end
      @(negedge clk);
      cyc++;
    end
    instr_ack = 1'b0;
    byte_valid = 1'b0;
    chk("stream_timeout", 64'(cyc >= 20000), 64'(0));
    chk("instr_count", 64'(obs_icnt), 64'(exp_icnt));
    chk("drop_count", 64'(obs_dcnt), 64'(exp_dcnt));
  endtask

  // Offer one byte until accepted; returns on the falling edge after acceptance.
  task automatic push_byte(input logic [7:0] b);
    int n;
    n = 0;
    byte_in = b;
    byte_valid = 1'b1;
    #1;
    while (!obs_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("push_byte_timeout", 64'(n), 64'(0));
    @(posedge clk);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic ack_one();
    instr_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_ack = 1'b0;
    exp_icnt++;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_icnt = 0;
    exp_dcnt = 0;
  endtask

  function automatic vec_t v(input logic [31:0] by, input int n, input logic [7:0] op,
                             input logic [7:0] m, input logic [15:0] d,
                             input logic mem, input logic [2:0] len);
    vec_t t;
    t.bytes = by; t.n = n; t.op = op; t.modrm = m;
    t.disp = d; t.has_mem = mem; t.len = len;
    return t;
  endfunction

  vec_t       tbl[12];
  logic [7:0] s[$];
  instr_t     e[$];
  instr_t     r;
  int         drops;

  initial begin
    tbl[0]  = v(32'hD9C10000, 2, 8'hD9, 8'hC1, 16'h0000, 1'b0, 3'd2);
    tbl[1]  = v(32'hDD46F000, 3, 8'hDD, 8'h46, 16'hFFF0, 1'b1, 3'd3);
    tbl[2]  = v(32'hD8063412, 4, 8'hD8, 8'h06, 16'h1234, 1'b1, 3'd4);
    tbl[3]  = v(32'h90000000, 1, 8'h90, 8'h00, 16'h0000, 1'b0, 3'd1);
    tbl[4]  = v(32'hD8C00000, 2, 8'hD8, 8'hC0, 16'h0000, 1'b0, 3'd2);
    tbl[5]  = v(32'hDEF90000, 2, 8'hDE, 8'hF9, 16'h0000, 1'b0, 3'd2);
    tbl[6]  = v(32'hDF457F00, 3, 8'hDF, 8'h45, 16'h007F, 1'b1, 3'd3);
    tbl[7]  = v(32'hDB2E7856, 4, 8'hDB, 8'h2E, 16'h5678, 1'b1, 3'd4);
    tbl[8]  = v(32'hDC860080, 4, 8'hDC, 8'h86, 16'h8000, 1'b1, 3'd4);
    tbl[9]  = v(32'hD9070000, 2, 8'hD9, 8'h07, 16'h0000, 1'b1, 3'd2);
    tbl[10] = v(32'hDA80FF7F, 4, 8'hDA, 8'h80, 16'h7FFF, 1'b1, 3'd4);
    tbl[11] = v(32'hDD7E8000, 3, 8'hDD, 8'h7E, 16'hFF80, 1'b1, 3'd3);

    reset = 1'b1; flush = 1'b0; byte_valid = 1'b0; instr_ack = 1'b0;
    byte_in = 8'h00; sel = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state
    chk("reset_valid", 64'(obs_valid), 64'(0));
    chk("reset_ready", 64'(obs_ready), 64'(1));
    chk("reset_fields", obs_fields(), 64'(0));
    chk("reset_counts", 64'({obs_icnt, obs_dcnt}), 64'(0));

    // Table vectors, ack three cycles after valid
    for (int t = 0; t < 12; t++) begin
      s.delete();
      for (int k = 0; k < tbl[t].n; k++) s.push_back(tbl[t].bytes[31-8*k -: 8]);
      r.op = tbl[t].op; r.modrm = tbl[t].modrm; r.disp = tbl[t].disp;
      r.has_mem = tbl[t].has_mem; r.len = tbl[t].len; r.end_idx = tbl[t].n - 1;
      e.delete();
      e.push_back(r);
      run_stream(s, e, 0, 3, 3);
    end

    // Idle stretch and gaps mid-instruction: fields must survive
    push_byte(8'hDC);
    repeat (5) @(negedge clk);
    chk("idle_no_valid", 64'(obs_valid), 64'(0));
    push_byte(8'h86);
    repeat (2) @(negedge clk);
    push_byte(8'h00);
    @(negedge clk);
    push_byte(8'h80);
    chk("gap_valid_latency", 64'(obs_valid), 64'(1));
    chk("gap_fields", obs_fields(), 64'({8'hDC, 8'h86, 16'h8000, 1'b1, 3'd4}));
    ack_one();

    // Flush a partial instruction; the byte offered during flush is not taken
    push_byte(8'hDC);
    push_byte(8'h86);
    push_byte(8'h00);
    flush = 1'b1;
    byte_valid = 1'b1;
    byte_in = 8'hD9;
    #1;
    chk("ready_low_during_flush", 64'(obs_ready), 64'(0));
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    byte_valid = 1'b0;
    chk("no_valid_after_flush", 64'(obs_valid), 64'(0));
    s = '{8'hD9, 8'hE8};
    model(s, 1'b1, e, drops);
    run_stream(s, e, 0, 0, 2);

    // Flush coinciding with ack: instruction dropped, not counted
    push_byte(8'hD9);
    push_byte(8'hC1);
    chk("present_before_flush_ack", 64'(obs_valid), 64'(1));
    flush = 1'b1;
    instr_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    instr_ack = 1'b0;
    chk("flush_ack_valid", 64'(obs_valid), 64'(0));
    chk("flush_ack_count", 64'(obs_icnt), 64'(exp_icnt));

    // Back-to-back instructions with immediate ack
    s = '{8'hD9, 8'hC1, 8'hD9, 8'hC2};
    model(s, 1'b1, e, drops);
    run_stream(s, e, 0, 0, 0);

    // Reset while presenting
    push_byte(8'hD9);
    push_byte(8'hC1);
    chk("present_before_reset", 64'(obs_valid), 64'(1));
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("reset_mid_valid", 64'(obs_valid), 64'(0));
    chk("reset_mid_ready", 64'(obs_ready), 64'(1));
    chk("reset_mid_counts", 64'({obs_icnt, obs_dcnt}), 64'(0));
    reset = 1'b0;
    exp_icnt = 0;
    exp_dcnt = 0;

    // Random streams, forwarding instance
    gen(150, 1'b1, s);
    model(s, 1'b1, e, drops);
    exp_dcnt += drops;
    run_stream(s, e, 30, 0, 3);

    // Dropping instance
    sel = 1'b1;
    pulse_reset();
    s = '{8'h90, 8'hD8, 8'hC0};
    model(s, 1'b0, e, drops);
    exp_dcnt += drops;
    run_stream(s, e, 0, 1, 1);
    chk("drop_one", 64'(obs_dcnt), 64'(1));
    gen(150, 1'b1, s);
    model(s, 1'b0, e, drops);
    exp_dcnt += drops;
    run_stream(s, e, 30, 0, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/esc_instruction_fetch_decoder.md
Name: esc_instruction_fetch_decoder

Overview:
Upstream stage of the CPU+FPU integrated system. It consumes the CPU prefetch-queue byte stream and parses each x87 ESC instruction (D8–DF). Parsing covers the opcode, the ModR/M byte and any 8/16-bit displacement. The block then presents one opcode/ModR/M pair at a time on a valid/ack handshake that matches the integrated system's instruction port. Non-ESC bytes are forwarded as one-byte instructions or dropped, selected by parameter.

Parameters:
PASS_NON_ESC, 1, 1 = forward non-ESC bytes as one-byte instructions (modrm=8'h00); 0 = consume and discard them
COUNT_W, 16, width of the instr_count and drop_count statistics counters

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
flush  input  1  abort current parse; discard held instruction (branch/queue flush)
byte_in  input  8  next prefetch-queue byte
byte_valid  input  1  byte_in valid
byte_ready  output  1  byte consumed on a cycle where byte_valid && byte_ready
instr_opcode  output  8  presented opcode
instr_modrm  output  8  presented ModR/M (8'h00 for non-ESC)
instr_disp  output  16  displacement, sign-extended when 8-bit; 0 if none
instr_has_mem  output  1  ESC with mod != 2'b11
instr_len  output  3  total bytes consumed for this instruction (1..4)
instr_valid  output  1  instruction presented
instr_ack  input  1  one-cycle acknowledge from consumer
instr_count  output  COUNT_W  instructions acknowledged (wraps)
drop_count  output  COUNT_W  non-ESC bytes discarded (PASS_NON_ESC=0; wraps)

Behaviour:
- Reset: state=S_OPCODE. All outputs 0: instr_valid, instr_opcode, instr_modrm, instr_disp, instr_has_mem, instr_len, both counters. byte_ready=1.
- All outputs are registered. instr_valid has no combinational dependence on instr_ack. byte_ready = (state != S_PRESENT).
- States: S_OPCODE, S_MODRM, S_DISP_LO, S_DISP_HI, S_PRESENT.
- S_OPCODE, on byte accept:
  - byte[7:3]==5'b11011: latch opcode, go to S_MODRM.
  - Otherwise, PASS_NON_ESC=1: latch opcode, modrm=0, disp=0, has_mem=0, len=1, go to S_PRESENT.
  - Otherwise, PASS_NON_ESC=0: drop_count+1, stay in S_OPCODE.
- S_MODRM, on accept, latch modrm, then branch on mod/rm:
  - mod=11: go to S_PRESENT, len=2, has_mem=0.
  - mod=01: go to S_DISP_LO (8-bit displacement).
  - mod=10: go to S_DISP_LO (16-bit displacement).
  - mod=00 and rm=110: go to S_DISP_LO (16-bit direct address).
  - mod=00, other rm: go to S_PRESENT, len=2, has_mem=1.
- S_DISP_LO, on accept:
  - 8-bit case: disp={{8{b[7]}},b}, len=3, go to S_PRESENT.
  - 16-bit case: disp[7:0]=b, go to S_DISP_HI.
- S_DISP_HI, on accept: disp[15:8]=b, len=4, go to S_PRESENT.
- instr_valid rises on the clock edge that enters S_PRESENT. Latency from the last instruction byte accepted to instr_valid is 1 cycle.
- S_PRESENT: outputs are held stable. When instr_ack is sampled high:
  - instr_valid clears on that edge; instr_count+1; go to S_OPCODE.
  - The next byte is accepted no earlier than the following cycle, so the consumer always sees valid low in its idle state and never recaptures.
- byte_valid low in any parse state: hold state and partially assembled fields, with no timeout.
- instr_ack while not in S_PRESENT: ignored. Counters do not change.
- flush (priority below reset, above everything else):
  - Next edge: state=S_OPCODE, instr_valid=0, partial fields cleared.
  - Any byte offered that cycle is not consumed; byte_ready=0 while flush is high.
  - Counters are not cleared.
- flush and instr_ack in the same cycle: flush wins; instr_count does not increment.
- Reset mid-parse or mid-present: return to the reset values on the next edge.
- Counters wrap modulo 2^COUNT_W.

Decomposition:
- Shared package fpu_decode_pkg:
  - ESC_PREFIX = 5'b11011
  - state enum localparams
  - mod-field constants MOD_NODISP/DISP8/DISP16/REG
  - RM_DIRECT = 3'b110
- Optional combinational sub-module esc_modrm_disp_len: maps (mod, rm) to {disp_bytes[1:0], has_mem}. The FSM and counters stay in the top module.

Test Plan:
- Stream D9 C1, byte_valid continuous, consumer acks 3 cycles after valid → opcode=D9, modrm=C1, has_mem=0, len=2, disp=0. byte_ready=0 while presenting. instr_count=1 after ack.
- Stream DD 46 F0 → disp=16'hFFF0 (sign-extended), has_mem=1, len=3. Stream D8 06 34 12 → disp=16'h1234, len=4.
- Stream 90 D8 C0 with PASS_NON_ESC=1 → first instr opcode=90, modrm=00, len=1, then D8/C0. With PASS_NON_ESC=0 → only D8/C0 presented; drop_count=1.
- Stream DC, idle 5 cycles, then 86 00 80 with byte_valid gaps → state holds. Result: disp=16'h8000, len=4, presented one cycle after the byte 80 is accepted.
- Flush asserted after DC 86 00, then D9 E8 → no instr_valid for the partial instruction. D9/E8 presented next with len=2. Flush coinciding with ack → instr_count unchanged.
- Reset asserted while in S_PRESENT with valid=1 → next cycle valid=0, byte_ready=1, counters=0. Back-to-back D9 C1 D9 C2 with ack → two instructions, valid low at least one cycle between them.
